// File: rtl/csr_unit.sv
// CSR execution unit: decodes csrrd/csrwr/csrxchg, owns the CSR bank and a free-running
// timer CSR, and returns the pre-write CSR value through a registered valid/ready stage.

`ifndef OP_INVALID
`define OP_INVALID 8'h00
`endif
`ifndef OP_CSRRD
`define OP_CSRRD 8'h01
`endif
`ifndef OP_CSRWR
`define OP_CSRWR 8'h02
`endif
`ifndef OP_CSRXCHG
`define OP_CSRXCHG 8'h03
`endif

module csr_unit #(
  parameter int                          NUM_CSR   = 16,
  parameter int                          DATA_W    = 32,
  parameter logic [NUM_CSR*DATA_W-1:0]   WMASK     = {NUM_CSR{{DATA_W{1'b1}}}},
  parameter int                          TIMER_IDX = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [DATA_W-1:0] in_rd_val,
  input  logic [DATA_W-1:0] in_rj_val,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_op,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_illegal
);

  typedef enum logic {IDLE, HOLD} state_t;

  function automatic logic [DATA_W-1:0] wmerge(input logic [DATA_W-1:0] old_v,
                                               input logic [DATA_W-1:0] new_v,
                                               input logic [DATA_W-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [DATA_W-1:0] csr_q [NUM_CSR];

  state_t            state_p1;
  logic              vld_p1;
  logic [7:0]        op_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic              illegal_p1;

  logic              is_csr_p0;
  logic              legal_p0;
  logic [13:0]       csr_num_p0;
  logic [4:0]        rj_p0;
  logic [7:0]        op_p0;
  logic [DATA_W-1:0] old_p0;
  logic [DATA_W-1:0] new_p0;
  logic              wr_p0;
  logic              accept;

  // Stage p0: decode and read the CSR bank combinationally from the request
  always_comb begin
    is_csr_p0  = (in_inst[31:24] == 8'h04);
    csr_num_p0 = in_inst[23:10];
    rj_p0      = in_inst[9:5];
    legal_p0   = is_csr_p0 && (int'(csr_num_p0) < NUM_CSR);

    if (!is_csr_p0)        op_p0 = `OP_INVALID;
    else if (rj_p0 == 5'd0) op_p0 = `OP_CSRRD;
    else if (rj_p0 == 5'd1) op_p0 = `OP_CSRWR;
    else                    op_p0 = `OP_CSRXCHG;

    old_p0 = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (legal_p0 && int'(csr_num_p0) == i) old_p0 = csr_q[i];
    end

    new_p0 = (rj_p0 == 5'd1) ? in_rd_val : wmerge(old_p0, in_rd_val, in_rj_val);
    wr_p0  = legal_p0 && (rj_p0 != 5'd0);
  end

  assign in_ready = ~flush & ((state_p1 == IDLE) | out_ready);
  assign accept   = in_valid & in_ready;

  // Writes commit at acceptance, so the next request always sees them without forwarding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CSR; i++) csr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (accept && wr_p0 && int'(csr_num_p0) == i)
          csr_q[i] <= wmerge(csr_q[i], new_p0, WMASK[i*DATA_W +: DATA_W]);
        else if (i == TIMER_IDX)
          csr_q[i] <= csr_q[i] + DATA_W'(1);
      end
    end
  end

  // Stage p1: registered result held until the consumer takes it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p1   <= IDLE;
      vld_p1     <= 1'b0;
      op_p1      <= `OP_INVALID;
      rdata_p1   <= '0;
      illegal_p1 <= 1'b0;
    end else if (flush) begin
      state_p1 <= IDLE;
      vld_p1   <= 1'b0;
    end else if (accept) begin
      state_p1   <= HOLD;
      vld_p1     <= 1'b1;
      op_p1      <= op_p0;
      rdata_p1   <= old_p0;
      illegal_p1 <= ~legal_p0;
    end else if (state_p1 == HOLD && out_ready) begin
      state_p1 <= IDLE;
      vld_p1   <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_op      = op_p1;
  assign out_rdata   = rdata_p1;
  assign out_illegal = illegal_p1;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: two instances, the second with a partial write mask on CSR 2.

module tb_csr_unit;

  localparam logic [7:0] OP_INV  = 8'h00;
  localparam logic [7:0] OP_RD   = 8'h01;
  localparam logic [7:0] OP_WR   = 8'h02;
  localparam logic [7:0] OP_XCHG = 8'h03;

  localparam logic [16*32-1:0] WM2 = {{13{32'hFFFFFFFF}}, 32'h0000FFFF, {2{32'hFFFFFFFF}}};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] in_rd_val = 32'h0;
  logic [31:0] in_rj_val = 32'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready,    in_ready2;
  logic        out_valid,   out_valid2;
  logic [7:0]  out_op,      out_op2;
  logic [31:0] out_rdata,   out_rdata2;
  logic        out_illegal, out_illegal2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rdata(out_rdata), .out_illegal(out_illegal)
  );

  csr_unit #(.NUM_CSR(16), .DATA_W(32), .WMASK(WM2), .TIMER_IDX(15)) dut_m (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_op(out_op2),
    .out_rdata(out_rdata2), .out_illegal(out_illegal2)
  );

  function automatic logic [31:0] csr_inst(input logic [13:0] num, input logic [4:0] rjf);
    return {8'h04, num, rjf, 5'd3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] inst, input logic [31:0] rd, input logic [31:0] rj);
    in_valid  = 1'b1;
    in_inst   = inst;
    in_rd_val = rd;
    in_rj_val = rj;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_op !== OP_INV) begin errors++; $display("FAIL reset_op: got %h want %h", out_op, OP_INV); end
    checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", out_rdata); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    step(); step();
    resetn = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_read();
    req(csr_inst(14'd3, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b want 1", out_valid); end
    checks++; if (out_op !== OP_RD) begin errors++; $display("FAIL rd_op: got %h want %h", out_op, OP_RD); end
    checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL rd_rdata: got %h want 0", out_rdata); end
    checks++; if (out_illegal !== 1'b0) begin errors++; $display("FAIL rd_illegal: got %b want 0", out_illegal); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    req(csr_inst(14'd2, 5'd1), 32'hDEADBEEF, 32'h0);
    step();
    checks++; if (out_op !== OP_WR) begin errors++; $display("FAIL b2b_wr_op: got %h want %h", out_op, OP_WR); end
    checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_old: got %h want 0", out_rdata); end
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
    checks++; if (out_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd: got %h want DEADBEEF", out_rdata); end
    step();
  endtask

  task automatic test_xchg();
    req(csr_inst(14'd2, 5'd1), 32'hFFFF0000, 32'h0);
    step();
    req(csr_inst(14'd2, 5'd7), 32'h12345678, 32'h00FF00FF);
    step();
    checks++; if (out_op !== OP_XCHG) begin errors++; $display("FAIL xchg_op: got %h want %h", out_op, OP_XCHG); end
    checks++; if (out_rdata !== 32'hFFFF0000) begin errors++; $display("FAIL xchg_old: got %h want FFFF0000", out_rdata); end
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    // (FFFF0000 & FF00FF00) | (12345678 & 00FF00FF)
    checks++; if (out_rdata !== 32'hFF340078) begin errors++; $display("FAIL xchg_new: got %h want FF340078", out_rdata); end
    step();
  endtask

  task automatic test_timer();
    logic [31:0] t0;
    req(csr_inst(14'd15, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    t0 = out_rdata;
    repeat (4) step();
    req(csr_inst(14'd15, 5'd0), 32'h0, 32'h0);
    step();
    checks++; if (out_rdata - t0 !== 32'd5) begin errors++; $display("FAIL timer_delta: got %0d want 5", out_rdata - t0); end
    req(csr_inst(14'd15, 5'd1), 32'hFFFFFFFE, 32'h0);
    step();
    req(csr_inst(14'd15, 5'd0), 32'h0, 32'h0);
    step();
    checks++; if (out_rdata !== 32'hFFFFFFFE) begin errors++; $display("FAIL timer_written: got %h want FFFFFFFE", out_rdata); end
    step();
    checks++; if (out_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL timer_inc: got %h want FFFFFFFF", out_rdata); end
    step();
    in_valid = 1'b0;
    checks++; if (out_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h want 0", out_rdata); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    req(csr_inst(14'd4, 5'd1), 32'h11111111, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_op !== OP_RD || out_rdata !== 32'hFF340078)
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b op=%h d=%h want v=1 op=%h d=FF340078", i, out_valid, out_op, out_rdata, OP_RD); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_op !== OP_WR || out_rdata !== 32'h0) begin errors++; $display("FAIL bp_next: got op=%h d=%h want op=%h d=0", out_op, out_rdata, OP_WR); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    req(csr_inst(14'd6, 5'd1), 32'hCAFEF00D, 32'h0);
    step();
    req(csr_inst(14'd6, 5'd0), 32'h0, 32'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL flush_kept_write: got v=%b d=%h want v=1 d=CAFEF00D", out_valid, out_rdata); end
    step();
  endtask

  task automatic test_illegal();
    req(32'h02800000, 32'h0, 32'h0);
    step();
    checks++; if (out_op !== OP_INV || out_illegal !== 1'b1 || out_rdata !== 32'h0)
      begin errors++; $display("FAIL ill_noncsr: got op=%h il=%b d=%h want op=%h il=1 d=0", out_op, out_illegal, out_rdata, OP_INV); end
    req(csr_inst(14'h100, 5'd1), 32'h55555555, 32'h0);
    step();
    checks++; if (out_op !== OP_WR || out_illegal !== 1'b1 || out_rdata !== 32'h0)
      begin errors++; $display("FAIL ill_range: got op=%h il=%b d=%h want op=%h il=1 d=0", out_op, out_illegal, out_rdata, OP_WR); end
    req(csr_inst(14'd0, 5'd0), 32'h0, 32'h0);
    step();
    checks++; if (out_rdata !== 32'h0 || out_illegal !== 1'b0) begin errors++; $display("FAIL ill_nowrite: got d=%h il=%b want d=0 il=0", out_rdata, out_illegal); end
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_rdata !== 32'hFF340078) begin errors++; $display("FAIL ill_csr2: got %h want FF340078", out_rdata); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_hold: got %b want 1", out_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_op !== OP_INV) begin errors++; $display("FAIL ar_drop: got v=%b op=%h want v=0 op=%h", out_valid, out_op, OP_INV); end
    resetn = 1'b1;
    out_ready = 1'b1;
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rdata !== 32'h0) begin errors++; $display("FAIL ar_cleared: got v=%b d=%h want v=1 d=0", out_valid, out_rdata); end
    step();
  endtask

  task automatic test_wmask();
    req(csr_inst(14'd2, 5'd1), 32'hAAAAAAAA, 32'h0);
    step();
    req(csr_inst(14'd2, 5'd0), 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    checks++; if (out_rdata2 !== 32'h0000AAAA) begin errors++; $display("FAIL wmask_masked: got %h want 0000AAAA", out_rdata2); end
    checks++; if (out_rdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL wmask_full: got %h want AAAAAAAA", out_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_back_to_back();
    test_xchg();
    test_timer();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_wmask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
